cache_d_2way_wb: RTL and testbench
==================================

# cache_d_2way_wb

Parametrised 2-way set-associative, write-back, write-allocate data cache between the pipelined RISC-V core's MEM stage and the 128-bit line memory. Compared with the fixed 4-set D-cache, this block adds:
- a configurable set count;
- per-way valid bits;
- a strict write-back-then-refill miss sequence, so the victim is evicted before the refill;
- saturating hit/miss/write-back performance counters.

## Interface

Parameters:
- ADDR_W, 30, processor word-address width
- SET_W, 2, log2(number of sets); sets = 2^SET_W
- CNT_W, 16, performance counter width

Ports:
- clk  in  1  single clock, all state on rising edge
- proc_reset  in  1  synchronous, active-high reset
- proc_read  in  1  load request
- proc_write  in  1  store request
- proc_addr  in  ADDR_W  word address: [1:0] word-in-line, [SET_W+1:2] index, [ADDR_W-1:SET_W+2] tag
- proc_wdata  in  32  store data
- proc_stall  out  1  combinational, high while a request cannot complete this cycle
- proc_rdata  out  32  combinational, load data of the hit way
- mem_read  out  1  registered line-read request
- mem_write  out  1  registered line-write request
- mem_addr  out  ADDR_W-2  registered line address {tag,index}
- mem_wdata  out  128  registered victim line
- mem_rdata  in  128  refill line, valid when mem_ready=1
- mem_ready  in  1  one-cycle completion pulse for the outstanding request
- hit_count  out  CNT_W  first-lookup hits
- miss_count  out  CNT_W  misses
- wb_count  out  CNT_W  dirty evictions

## Operation

- Storage per set:
  - 2 ways, each holding a 128-bit line, a tag of ADDR_W-SET_W-2 bits, a valid bit and a dirty bit;
  - 1 LRU bit per set, which names the victim way.
- Hit: the indexed way is valid and its tag equals proc_addr's tag. hit_way selects the returned word, which is proc_addr[1:0] × 32 bits of the line.
- Request: proc_read or proc_write is high. If both are high, the request is a store.
- FSM states are READY, WB and FILL.
  - READY, no request: idle, proc_stall=0.
  - READY, request hits:
    - proc_stall=0.
    - A store writes the word and sets that way's dirty bit.
    - LRU is set to the other way.
  - READY, request misses:
    - proc_stall=1 and miss_count increments.
    - Victim selection: an invalid way first, way0 before way1; otherwise the LRU way.
    - Victim valid and dirty: go to WB with mem_write=1, mem_addr={victim tag,index}, mem_wdata=victim line. wb_count increments.
    - Otherwise go to FILL with mem_read=1 and mem_addr=proc_addr[ADDR_W-1:2].
  - WB, proc_stall=1:
    - On mem_ready: mem_write=0 and mem_read=1, with mem_addr set to the requested line.
    - Next state is FILL.
  - FILL, proc_stall=1:
    - On mem_ready: the victim way takes mem_rdata and the new tag, with valid=1 and dirty=0.
    - mem_read=0; next state is READY.
- Retry after refill: the request is re-evaluated in READY. It now hits, completes, and for a store merges proc_wdata and sets dirty. This retry hit does not increment hit_count; a one-bit "refilled" flag suppresses it.
- mem_read and mem_write are never high together. Each is held high until the cycle after mem_ready is sampled.
- Counters saturate at all-ones and never wrap.
- The processor holds the request stable while proc_stall=1.

## Timing

- Reset values:
  - state READY;
  - proc_stall follows the combinational rules; it is 0 with no request;
  - mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0;
  - all valid, dirty and LRU bits 0; counters 0;
  - line/tag contents don't-care but deterministic, 0.
- Hit latency is 0. Stall is low in the request cycle, and store data is written at that cycle's edge.
- Clean miss, request in cycle 0:
  - mem_read high from cycle 1;
  - mem_ready in cycle k means the line is written at the end of cycle k;
  - stall is low in cycle k+1, so total stall is k+1 cycles.
- Dirty miss:
  - mem_write high from cycle 1;
  - mem_ready in cycle j, then mem_read high from cycle j+1;
  - mem_ready in cycle k, then stall is low in k+1.
- mem_ready outside WB/FILL is ignored.
- Reset mid-miss drops mem_read/mem_write at the next edge and discards the pending fill. The memory model must tolerate an abandoned request.
- Index wrap: the top index set aliases nothing, and tags are compared in full.

## Test plan

1. Reset, read addr 0x10, mem_ready after 3 cycles with line 0x4444_3333_2222_1111:
   - mem_read for exactly cycles 1-3 with mem_addr=0x4;
   - rdata=0x1111 at cycle 4;
   - miss_count=1, hit_count=0.
2. Read 0x11 after test 1 → stall=0 same cycle, rdata=0x2222, hit_count=1.
3. Store 0xDEAD to 0x12, then read 0x12 → no stall, rdata=0xDEAD, dirty set, no memory traffic.
4. Fill both ways of set 0 (0x00, 0x40) with way0 dirty, touch 0x40, then read 0x80:
   - mem_write with mem_addr=0x0 and line containing 0xDEAD;
   - then mem_read with mem_addr=0x20;
   - never both high; wb_count=1.
5. Assert proc_reset during FILL → mem_read=0 next cycle, counters 0, a subsequent read of the same address misses again.
6. With CNT_W=4, 20 hits → hit_count stays at 0xF.

Source files
------------

// File: rtl/cache_d_2way_wb.sv
// cache_d_2way_wb: 2-way set-associative, write-back, write-allocate data cache.
// A miss first evicts a dirty victim line, then refills the requested line, and
// the held request is retried as a hit. Saturating hit/miss/write-back counters.
module cache_d_2way_wb #(
    parameter int ADDR_W = 30,
    parameter int SET_W  = 2,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              proc_reset,
    input  logic              proc_read,
    input  logic              proc_write,
    input  logic [ADDR_W-1:0] proc_addr,
    input  logic [31:0]       proc_wdata,
    output logic              proc_stall,
    output logic [31:0]       proc_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [127:0]      mem_wdata,
    input  logic [127:0]      mem_rdata,
    input  logic              mem_ready,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count,
    output logic [CNT_W-1:0]  wb_count
);
    localparam int TAG_W = ADDR_W - SET_W - 2;
    localparam int SETS  = 1 << SET_W;

    typedef enum logic [1:0] {READY, WB, FILL} state_e;

    state_e state_q, state_d;

    // Line storage, one entry per way and set
    logic [127:0]     line_q  [2][SETS];
    logic [TAG_W-1:0] tag_q   [2][SETS];
    logic [SETS-1:0]  valid_q [2];
    logic [SETS-1:0]  dirty_q [2];
    logic [SETS-1:0]  lru_q;            // names the victim way of each set

    // Registered memory port and bookkeeping
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-3:0] mem_addr_q, mem_addr_d;
    logic [127:0]      mem_wdata_q, mem_wdata_d;
    logic              victim_q, victim_d;
    logic              refilled_q, refilled_d;
    logic [CNT_W-1:0]  hit_cnt_q, miss_cnt_q, wb_cnt_q;

    // Per-cycle actions decided by the FSM
    logic hit_inc, miss_inc, wb_inc;
    logic store_we, fill_we, touch;

    // Request decode
    logic             req;
    logic [SET_W-1:0] idx;
    logic [TAG_W-1:0] req_tag;
    logic [6:0]       word_off;
    logic             hit0, hit1, hit, hit_way;
    logic             vict_way;
    logic [127:0]     hit_line;

    assign req      = proc_read | proc_write;
    assign idx      = proc_addr[SET_W+1:2];
    assign req_tag  = proc_addr[ADDR_W-1:SET_W+2];
    assign word_off = {proc_addr[1:0], 5'd0};

    assign hit0    = valid_q[0][idx] && (tag_q[0][idx] == req_tag);
    assign hit1    = valid_q[1][idx] && (tag_q[1][idx] == req_tag);
    assign hit     = hit0 | hit1;
    assign hit_way = hit1;

    assign hit_line   = line_q[hit_way][idx];
    assign proc_rdata = hit_line[word_off +: 32];

    // Invalid way first (way0 before way1), otherwise the LRU way
    assign vict_way = !valid_q[0][idx] ? 1'b0 :
                      !valid_q[1][idx] ? 1'b1 : lru_q[idx];

    assign mem_read   = mem_read_q;
    assign mem_write  = mem_write_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
    assign wb_count   = wb_cnt_q;

    // Next-state, memory-port requests and storage update enables
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // a variable unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        victim_d    = victim_q;
        refilled_d  = refilled_q;
        proc_stall  = 1'b0;
        hit_inc     = 1'b0;
        miss_inc    = 1'b0;
        wb_inc      = 1'b0;
        store_we    = 1'b0;
        fill_we     = 1'b0;
        touch       = 1'b0;
        case (state_q)
            READY: begin
                refilled_d = 1'b0;
                if (req) begin
                    if (hit) begin
                        touch    = 1'b1;
                        store_we = proc_write;
                        hit_inc  = ~refilled_q;   // the post-refill retry is not a hit
                    end else begin
                        proc_stall = 1'b1;
                        miss_inc   = 1'b1;
                        victim_d   = vict_way;
                        if (valid_q[vict_way][idx] && dirty_q[vict_way][idx]) begin
                            state_d     = WB;
                            mem_write_d = 1'b1;
                            mem_addr_d  = {tag_q[vict_way][idx], idx};
                            mem_wdata_d = line_q[vict_way][idx];
                            wb_inc      = 1'b1;
                        end else begin
                            state_d    = FILL;
                            mem_read_d = 1'b1;
                            mem_addr_d = proc_addr[ADDR_W-1:2];
                        end
                    end
                end
            end
            WB: begin
                proc_stall = 1'b1;
                if (mem_ready) begin
                    state_d     = FILL;
                    mem_write_d = 1'b0;
                    mem_read_d  = 1'b1;
                    mem_addr_d  = proc_addr[ADDR_W-1:2];
                end
            end
            FILL: begin
                proc_stall = 1'b1;
                if (mem_ready) begin
                    state_d    = READY;
                    mem_read_d = 1'b0;
                    fill_we    = 1'b1;
                    refilled_d = 1'b1;
                end
            end
            default: state_d = READY;
        endcase
    end

    // FSM state, memory-port registers and saturating counters
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (proc_reset) begin
            state_q     <= READY;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            victim_q    <= 1'b0;
            refilled_q  <= 1'b0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
            wb_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            victim_q    <= victim_d;
            refilled_q  <= refilled_d;
            if (hit_inc && hit_cnt_q != '1)
                hit_cnt_q <= hit_cnt_q + CNT_W'(1);
            if (miss_inc && miss_cnt_q != '1)
                miss_cnt_q <= miss_cnt_q + CNT_W'(1);
            if (wb_inc && wb_cnt_q != '1)
                wb_cnt_q <= wb_cnt_q + CNT_W'(1);
        end
    end

    // Line, tag, valid, dirty and LRU storage updates
    always_ff @(posedge clk) begin
        if (proc_reset) begin
            // NOTE: the line/tag arrays are cleared too so contents after reset
            // are deterministic; only valid bits are needed for correctness.
            for (int w = 0; w < 2; w++) begin
                valid_q[w] <= '0;
                dirty_q[w] <= '0;
                for (int s = 0; s < SETS; s++) begin
                    line_q[w][s] <= '0;
                    tag_q[w][s]  <= '0;
                end
            end
            lru_q <= '0;
        end else begin
            if (fill_we) begin
                line_q[victim_q][idx]  <= mem_rdata;
                tag_q[victim_q][idx]   <= req_tag;
                valid_q[victim_q][idx] <= 1'b1;
                dirty_q[victim_q][idx] <= 1'b0;
            end
            if (store_we) begin
                line_q[hit_way][idx][word_off +: 32] <= proc_wdata;
                dirty_q[hit_way][idx]                <= 1'b1;
            end
            if (touch)
                lru_q[idx] <= ~hit_way;
        end
    end

endmodule

// File: tb/tb_cache_d_2way_wb.sv
// tb_cache_d_2way_wb: directed and randomized checks of cache_d_2way_wb against
// a reference built from recency-ordered residency per set and a flat memory view.
module tb_cache_d_2way_wb;
    localparam int ADDR_W = 30;
    localparam int SET_W  = 2;
    localparam int CNT_W  = 4;
    localparam int LA_W   = ADDR_W - 2;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              proc_reset = 1'b0;
    logic              proc_read = 1'b0;
    logic              proc_write = 1'b0;
    logic [ADDR_W-1:0] proc_addr = '0;
    logic [31:0]       proc_wdata = '0;
    logic              proc_stall;
    logic [31:0]       proc_rdata;
    logic              mem_read;
    logic              mem_write;
    logic [LA_W-1:0]   mem_addr;
    logic [127:0]      mem_wdata;
    logic [127:0]      mem_rdata = '1;
    logic              mem_ready = 1'b0;
    logic [CNT_W-1:0]  hit_count;
    logic [CNT_W-1:0]  miss_count;
    logic [CNT_W-1:0]  wb_count;

    always #5 clk = ~clk;

    cache_d_2way_wb #(.ADDR_W(ADDR_W), .SET_W(SET_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .proc_reset (proc_reset),
        .proc_read  (proc_read),
        .proc_write (proc_write),
        .proc_addr  (proc_addr),
        .proc_wdata (proc_wdata),
        .proc_stall (proc_stall),
        .proc_rdata (proc_rdata),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .hit_count  (hit_count),
        .miss_count (miss_count),
        .wb_count   (wb_count)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: each set holds up to two line addresses, [0] most recent.
    typedef struct packed {
        logic [LA_W-1:0] la;
        logic            dirty;
    } slot_t;

    slot_t        slot  [4][2];
    int           n_res [4];
    logic [127:0] backing [logic [LA_W-1:0]];   // what memory holds
    logic [127:0] arch    [logic [LA_W-1:0]];   // newer data held dirty in the cache
    int           exp_hit, exp_miss, exp_wb;

    function automatic logic [127:0] init_line(input logic [LA_W-1:0] la);
        logic [127:0] l;
        for (int i = 0; i < 4; i++) l[i*32 +: 32] = {la, 2'(i), 2'b01};
        return l;
    endfunction

    function automatic logic [127:0] mem_get(input logic [LA_W-1:0] la);
        return backing.exists(la) ? backing[la] : init_line(la);
    endfunction

    function automatic logic [127:0] arch_get(input logic [LA_W-1:0] la);
        return arch.exists(la) ? arch[la] : mem_get(la);
    endfunction

    function automatic int sat(input int x);
        return (x >= CMAX) ? CMAX : x + 1;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 4; s++) n_res[s] = 0;
        arch.delete();
        exp_hit  = 0;
        exp_miss = 0;
        exp_wb   = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        proc_reset = 1'b1; proc_read = 1'b0; proc_write = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        proc_reset = 1'b0;
        #1;
        model_reset();
        check("rst_stall", proc_stall, 0);
        check("rst_mem_read", mem_read, 0);
        check("rst_mem_write", mem_write, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_hit_count", hit_count, 0);
        check("rst_miss_count", miss_count, 0);
        check("rst_wb_count", wb_count, 0);
    endtask

    // Idle cycles; optionally a stray mem_ready that must be ignored.
    task automatic idle(input int n, input bit stray);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            proc_read = 1'b0; proc_write = 1'b0;
            mem_ready = stray && (c == 0);
            mem_rdata = '1;
            #1;
            check("idle_stall", proc_stall, 0);
            check("idle_mem_read", mem_read, 0);
            check("idle_mem_write", mem_write, 0);
        end
        check("hit_count", hit_count, exp_hit);
        check("miss_count", miss_count, exp_miss);
        check("wb_count", wb_count, exp_wb);
    endtask

    // One processor access with cycle-exact memory handshake expectations.
    task automatic access(input bit is_wr, input logic [ADDR_W-1:0] addr,
                          input logic [31:0] wdata, input int lat_w, input int lat_r);
        logic [LA_W-1:0] la;
        logic [127:0]    line;
        slot_t           vic, tmp;
        int              s, w, pos;
        bit              dirty_vic;
        la  = addr[ADDR_W-1:2];
        s   = int'(addr[3:2]);
        w   = int'(addr[1:0]);
        pos = -1;
        for (int i = 0; i < n_res[s]; i++) if (slot[s][i].la == la) pos = i;
        @(negedge clk);
        proc_read = !is_wr; proc_write = is_wr; proc_addr = addr; proc_wdata = wdata;
        mem_ready = 1'b0; mem_rdata = '1;
        #1;
        if (pos < 0) begin
            check("miss_stall", proc_stall, 1);
            exp_miss  = sat(exp_miss);
            dirty_vic = 1'b0;
            vic       = '0;
            if (n_res[s] == 2) begin
                vic       = slot[s][1];
                dirty_vic = vic.dirty;
            end
            if (dirty_vic) begin
                exp_wb = sat(exp_wb);
                for (int c = 1; c <= lat_w; c++) begin
                    @(negedge clk);
                    mem_ready = (c == lat_w);
                    #1;
                    check("wb_stall", proc_stall, 1);
                    check("wb_mem_write", mem_write, 1);
                    check("wb_mem_read", mem_read, 0);
                    check("wb_mem_addr", mem_addr, vic.la);
                    check("wb_mem_wdata", mem_wdata, arch_get(vic.la));
                end
                backing[vic.la] = arch_get(vic.la);
                arch.delete(vic.la);
            end
            for (int c = 1; c <= lat_r; c++) begin
                @(negedge clk);
                mem_ready = (c == lat_r);
                mem_rdata = (c == lat_r) ? mem_get(la) : '1;
                #1;
                check("fill_stall", proc_stall, 1);
                check("fill_mem_read", mem_read, 1);
                check("fill_mem_write", mem_write, 0);
                check("fill_mem_addr", mem_addr, la);
            end
            if (n_res[s] >= 1) slot[s][1] = slot[s][0];
            slot[s][0].la    = la;
            slot[s][0].dirty = 1'b0;
            if (n_res[s] < 2) n_res[s]++;
            @(negedge clk);
            mem_ready = 1'b0; mem_rdata = '1;
            #1;
            check("retry_stall", proc_stall, 0);
            check("retry_mem_read", mem_read, 0);
            check("retry_mem_write", mem_write, 0);
        end else begin
            check("hit_stall", proc_stall, 0);
            exp_hit = sat(exp_hit);
            if (pos == 1) begin
                tmp        = slot[s][1];
                slot[s][1] = slot[s][0];
                slot[s][0] = tmp;
            end
        end
        line = arch_get(la);
        if (!is_wr) begin
            check("rdata", proc_rdata, line[w*32 +: 32]);
        end else begin
            line[w*32 +: 32] = wdata;
            arch[la]         = line;
            slot[s][0].dirty = 1'b1;
        end
    endtask

    initial begin
        logic [ADDR_W-1:0] addr;
        logic [25:0]       tg;
        int                tsel;

        model_reset();

        // Reset, clean read miss with a 3-cycle memory, then a hit in the same line
        do_reset();
        backing[28'h4] = 128'h0000_4444_0000_3333_0000_2222_0000_1111;
        access(1'b0, 30'h10, 32'h0, 1, 3);
        idle(1, 1'b0);
        access(1'b0, 30'h11, 32'h0, 1, 1);
        idle(1, 1'b0);

        // Store hit then read back, with no memory traffic
        access(1'b1, 30'h12, 32'h0000_DEAD, 1, 1);
        access(1'b0, 30'h12, 32'h0, 1, 1);
        idle(2, 1'b1);

        // Dirty eviction: way0 holds 0xDEAD, 0x40 is touched, 0x80 evicts line 0
        do_reset();
        access(1'b1, 30'h00, 32'h0000_DEAD, 1, 2);
        access(1'b0, 30'h40, 32'h0, 1, 2);
        access(1'b0, 30'h40, 32'h0, 1, 1);
        access(1'b0, 30'h80, 32'h0, 2, 3);
        idle(1, 1'b0);

        // Reset while a fill is outstanding
        do_reset();
        @(negedge clk);
        proc_read = 1'b1; proc_write = 1'b0; proc_addr = 30'h24;
        #1;
        check("abort_miss_stall", proc_stall, 1);
        @(negedge clk);
        #1;
        check("abort_mem_read", mem_read, 1);
        @(negedge clk);
        proc_reset = 1'b1;
        @(negedge clk);
        proc_reset = 1'b0; proc_read = 1'b0;
        #1;
        model_reset();
        check("abort_drop_read", mem_read, 0);
        check("abort_miss_count", miss_count, 0);
        check("abort_hit_count", hit_count, 0);
        access(1'b0, 30'h24, 32'h0, 1, 2);
        idle(1, 1'b0);

        // Hit counter saturates
        for (int i = 0; i < 20; i++) access(1'b0, 30'h25, 32'h0, 1, 1);
        idle(1, 1'b0);
        check("hit_count_sat", hit_count, CMAX);

        // Randomized traffic, including a far tag that aliases tag 1 if truncated
        do_reset();
        for (int n = 0; n < 300; n++) begin
            tsel = int'($urandom_range(0, 4));
            tg   = (tsel == 4) ? 26'h200_0001 : 26'(tsel);
            addr = {tg, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
            access($urandom_range(0, 1) == 1, addr, $urandom,
                   int'($urandom_range(1, 4)), int'($urandom_range(1, 4)));
            if ($urandom_range(0, 5) == 0) idle(1, $urandom_range(0, 1) == 1);
            if ($urandom_range(0, 60) == 0) do_reset();
        end
        idle(1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
